// File: rtl/mux_pkg.sv
// Shared definitions for the scan/direct channel multiplexer.
// Mode encodings and the select-width helper used to size channel indices.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Select width never drops below one bit, even for a two-channel mux.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_tree.sv
// Combinational N:1 W-bit multiplexer built from levels of 2:1 muxes.
// Leaves are padded to a power of two; padding leaves read as zero.
module mux_tree
  import mux_pkg::*;
#(
  parameter int N = 13,
  parameter int W = 8,
  localparam int SW = clog2_min1(N)
) (
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data
);

  localparam int L = 1 << SW;

  // Level 0 holds the leaves; level gj halves the width using sel[gj-1].
  for (genvar gj = 0; gj <= SW; gj++) begin : g_lvl
    logic [W-1:0] w_lvl [L >> gj];

    if (gj == 0) begin : g_leaf
      for (genvar gi = 0; gi < L; gi++) begin : g_in
        if (gi < N) begin : g_used
          assign w_lvl[gi] = in_data[gi*W +: W];
        end else begin : g_pad
          assign w_lvl[gi] = '0;
        end
      end
    end else begin : g_mux
      for (genvar gk = 0; gk < (L >> gj); gk++) begin : g_node
        assign w_lvl[gk] = sel[gj-1] ? g_lvl[gj-1].w_lvl[2*gk+1]
                                     : g_lvl[gj-1].w_lvl[2*gk];
      end
    end
  end

  assign out_data = g_lvl[SW].w_lvl[0];

endmodule

// File: rtl/mux_scan_reg.sv
// N:1 multiplexer with registered output, valid/ready handshake and a
// round-robin scan mode that walks channels 0..N-1 one capture at a time.
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter int N = 13,
  parameter int W = 8,
  localparam int SW = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           scan_clr,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_err,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [SW:0]   LP_N    = (SW+1)'(N);
  localparam logic [SW-1:0] LP_LAST = SW'(N - 1);

  logic [SW-1:0] r_scan_ptr;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_ch;
  logic          r_out_err;
  logic          r_out_valid;

  logic          w_in_ready;
  logic          w_cap;
  logic          w_scan;
  logic [SW-1:0] w_ch;
  logic          w_in_range;
  logic [W-1:0]  w_tree_data;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_cap      = in_valid && w_in_ready;
  assign w_scan     = (mode == MODE_SCAN);

  // A pending scan_clr makes this capture sample channel 0, not the stale pointer.
  assign w_ch       = w_scan ? (scan_clr ? '0 : r_scan_ptr) : sel;
  assign w_in_range = ({1'b0, w_ch} < LP_N);

  mux_tree #(
    .N (N),
    .W (W)
  ) u_tree (
    .in_data  (in_data),
    .sel      (w_ch),
    .out_data (w_tree_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_cap) begin
      r_out_data  <= w_in_range ? w_tree_data : '0;
      r_out_ch    <= w_ch;
      r_out_err   <= !w_in_range;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // After a clear that coincides with a scan capture, channel 0 is consumed,
  // so the pointer moves straight on to channel 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_ptr <= '0;
    end else if (scan_clr) begin
      r_scan_ptr <= (w_cap && w_scan) ? SW'(1) : '0;
    end else if (w_cap && w_scan) begin
      r_scan_ptr <= (r_scan_ptr == LP_LAST) ? '0 : r_scan_ptr + SW'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Randomised and directed bench for mux_scan_reg against an integer-level
// model of the capture/hold/drain and scan-pointer rules.
module tb_mux_scan_reg;

  localparam int N  = 13;
  localparam int W  = 8;
  localparam int SW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           scan_clr;
  logic           in_valid;
  logic           out_ready;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_err;
  logic           out_valid;

  always #5 clk = ~clk;

  mux_scan_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .scan_clr  (scan_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Model state
  bit         m_valid;
  bit         m_err;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_ptr   = 0;
  endtask

  task automatic model_update();
    int ch;
    bit rdy;
    bit cap;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rdy = !m_valid || out_ready;
    cap = in_valid && rdy;
    ch  = mode ? (scan_clr ? 0 : m_ptr) : int'(sel);
    if (cap) begin
      m_valid = 1'b1;
      m_ch    = ch;
      m_err   = (ch >= N);
      m_data  = (ch < N) ? in_data[ch*W +: W] : 8'h00;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (scan_clr) m_ptr = (cap && mode) ? 1 : 0;
    else if (cap && mode) m_ptr = (m_ptr + 1) % N;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic load_pattern();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'(8'h10 + k);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data",  32'(out_data),  32'(m_data));
      check("out_ch",    32'(out_ch),    32'(m_ch));
      check("out_err",   32'(out_err),   32'(m_err));
      if (out_valid && out_ready)
        $display("txn ch=%0d data=%02h err=%0d t=%0t", out_ch, out_data, out_err, $time);
    end
  end

  int exp_seq [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 0, 1};

  initial begin
    rst_n     = 1'b0;
    sel       = '0;
    mode      = 1'b0;
    scan_clr  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    load_pattern();
    model_reset();
    cmp_en = 1'b1;
    tick();
    tick();
    check("reset_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // Direct mode, in range
    sel = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("direct_data",  32'(out_data), 32'h15);
    check("direct_ch",    32'(out_ch),   32'd5);
    check("direct_err",   32'(out_err),  32'd0);
    check("direct_valid", 32'(out_valid), 32'd1);

    // Direct mode, out of range index
    sel = 4'd14;
    tick();
    check("oor_data", 32'(out_data), 32'h00);
    check("oor_ch",   32'(out_ch),   32'd14);
    check("oor_err",  32'(out_err),  32'd1);

    // Scan wrap, one sample per clock
    mode = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("scan_ch",   32'(out_ch),   32'(exp_seq[i]));
      check("scan_data", 32'(out_data), 32'(8'h10 + exp_seq[i]));
    end

    // Backpressure: held sample frozen, pointer not advanced
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_ch",    32'(out_ch),   32'd1);
      check("bp_data",  32'(out_data), 32'h11);
    end
    out_ready = 1'b1;
    tick();
    check("bp_resume_ch", 32'(out_ch), 32'd2);

    // Advance pointer to 7, then collide scan_clr with a capture
    for (int i = 0; i < 4; i++) tick();
    check("pre_clr_ch", 32'(out_ch), 32'd6);
    scan_clr = 1'b1;
    tick();
    check("clr_ch", 32'(out_ch), 32'd0);
    scan_clr = 1'b0;
    tick();
    check("clr_next_ch", 32'(out_ch), 32'd1);

    // Asynchronous reset while a sample is held
    out_ready = 1'b0;
    tick();
    check("held_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data",  32'(out_data),  32'd0);
    check("arst_ch",    32'(out_ch),    32'd0);
    check("arst_err",   32'(out_err),   32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;

    // Randomised phase
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = 4'($urandom_range(0, 15));
      scan_clr  = 1'($urandom_range(0, 19) == 0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_arst_valid", 32'(out_valid), 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
